if_fetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage for the RV32I pipeline; the successor to the combinational PC mux/adder fetch.

---
 rtl/if_fetch_unit_if.sv | 40 ++++
 rtl/if_fetch_unit.sv | 119 +++++++++++
 tb/tb_if_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_fetch_unit_if : redirect, instruction-memory and ID-side buses     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface if_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            pc_src;
  logic [1:0]      jump;
  logic [XLEN-1:0] branch_addr;
  logic [XLEN-1:0] jump_addr;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc4;

  modport master (
    input  pc_src, jump, branch_addr, jump_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr,
    output id_valid, id_inst, id_pc, id_pc4
  );

  modport slave (
    output pc_src, jump, branch_addr, jump_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr,
    input  id_valid, id_inst, id_pc, id_pc4
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_fetch_unit : PC owner, pipelined imem requester, DEPTH-entry      |
// | fetch buffer feeding ID. Rev 1.0 - initial release                   |
// +----------------------------------------------------------------------+
module if_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  if_fetch_unit_if.master bus
);
  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic            run_q;

  logic [XLEN-1:0] tag_mem  [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pcb_mem  [DEPTH];

  logic            w_jump, w_redirect, w_req_valid, w_accept;
  logic            w_rsp, w_push, w_pop, w_nonempty;
  logic [XLEN-1:0] w_sel, w_target, w_head_pc;
  logic [CW-1:0]   w_occupancy;

  assign w_jump     = (bus.jump == 2'b01) || (bus.jump == 2'b10);
  assign w_redirect = w_jump || bus.pc_src;
  assign w_sel      = w_jump ? bus.jump_addr : bus.branch_addr;
  assign w_target   = {w_sel[XLEN-1:2], 2'b00};

  // Credit: requests in flight plus buffered words can never exceed the buffer,
  // so every response that is not dropped is guaranteed a free slot.
  assign w_occupancy = inflight_q + count_q;
  assign w_req_valid = run_q && !w_redirect && (w_occupancy < C_DEPTH);
  assign w_accept    = w_req_valid && bus.imem_req_ready;
  assign w_rsp       = bus.imem_rsp_valid && (inflight_q != '0);
  assign w_push      = w_rsp && !w_redirect && (drop_q == '0);
  assign w_nonempty  = (count_q != '0);
  assign w_pop       = w_nonempty && !w_redirect && bus.id_ready;

  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CW'(w_accept) - CW'(w_rsp);
    tag_wr_d   = tag_wr_q + AW'(w_accept);
    tag_rd_d   = tag_rd_q + AW'(w_rsp);
    if (w_redirect) begin
      pc_d    = w_target;
      count_d = '0;
      rd_d    = wr_q;
      drop_d  = inflight_d;
    end else begin
      if (w_accept) begin
        pc_d = pc_q + XLEN'(4);
      end
      count_d = count_q + CW'(w_push) - CW'(w_pop);
      wr_d    = wr_q + AW'(w_push);
      rd_d    = rd_q + AW'(w_pop);
      drop_d  = drop_q - CW'(w_rsp && (drop_q != '0));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_VECTOR;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      run_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      run_q      <= 1'b1;
    end
  end

  // The tag queue pairs each in-order response with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      tag_mem[tag_wr_q] <= pc_q;
    end
    if (w_push) begin
      inst_mem[wr_q] <= bus.imem_rsp_data;
      pcb_mem[wr_q]  <= tag_mem[tag_rd_q];
    end
  end

  assign w_head_pc          = w_nonempty ? pcb_mem[rd_q] : '0;
  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.id_valid       = w_nonempty && !w_redirect;
  assign bus.id_inst        = w_nonempty ? inst_mem[rd_q] : '0;
  assign bus.id_pc          = w_head_pc;
  assign bus.id_pc4         = w_nonempty ? (w_head_pc + XLEN'(4)) : '0;
endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// tb_if_fetch_unit : directed scenarios against a queue-based model of the fetch stage
// (sequential PCs, redirect flush/drop, credit-limited buffering).
module tb_if_fetch_unit;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  if_fetch_unit_if #(.XLEN(XLEN)) bus ();

  if_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          lat   = 1;
  mreq_t       memq[$];
  logic [31:0] acc_log[$];
  logic [31:0] dlv_log[$];

  logic [31:0] m_outq[$];
  logic [31:0] m_fifo[$];
  int          m_drop = 0;
  logic [31:0] m_addr = RV;
  bit          m_run  = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic        jmp, redir, exp_rv, exp_iv;
    logic [31:0] tgt, head;
    mreq_t       r;
    jmp    = (bus.jump == 2'b01) || (bus.jump == 2'b10);
    redir  = jmp || bus.pc_src;
    tgt    = jmp ? bus.jump_addr : bus.branch_addr;
    tgt    = tgt & 32'hFFFF_FFFC;
    exp_rv = m_run && !redir && ((m_outq.size() + m_fifo.size()) < DEPTH);
    exp_iv = !redir && (m_fifo.size() != 0);

    chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", bus.imem_req_addr, m_addr);
    chk("id_valid", 32'(bus.id_valid), 32'(exp_iv));
    if (exp_iv) begin
      head = m_fifo[0];
      chk("id_pc", bus.id_pc, head);
      chk("id_inst", bus.id_inst, mem_word(head));
      chk("id_pc4", bus.id_pc4, head + 32'd4);
    end

    if (bus.imem_req_valid && bus.imem_req_ready) begin
      r.addr = bus.imem_req_addr;
      r.due  = cyc + lat;
      memq.push_back(r);
      acc_log.push_back(bus.imem_req_addr);
    end
    if (bus.id_valid && bus.id_ready) dlv_log.push_back(bus.id_pc);

    m_run = 1'b1;
    if (redir) begin
      if (bus.imem_rsp_valid && m_outq.size() > 0) m_outq.delete(0);
      m_fifo.delete();
      m_drop = m_outq.size();
      m_addr = tgt;
    end else begin
      if (exp_iv && bus.id_ready) m_fifo.delete(0);
      if (bus.imem_rsp_valid && m_outq.size() > 0) begin
        head = m_outq[0];
        m_outq.delete(0);
        if (m_drop > 0) m_drop--;
        else m_fifo.push_back(head);
      end
      if (exp_rv && bus.imem_req_ready) begin
        m_outq.push_back(m_addr);
        m_addr = m_addr + 32'd4;
      end
    end
  endtask

  // Instruction memory responder plus per-cycle compare against the model.
  initial begin : env
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (reset && memq.size() > 0 && memq[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(memq[0].addr);
        memq.delete(0);
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
      @(negedge clk);
      if (!reset) begin
        memq.delete();
        m_outq.delete();
        m_fifo.delete();
        m_drop = 0;
        m_addr = RV;
        m_run  = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic set_redirect(input logic src, input logic [1:0] j,
                              input logic [31:0] baddr, input logic [31:0] jaddr);
    bus.pc_src      = src;
    bus.jump        = j;
    bus.branch_addr = baddr;
    bus.jump_addr   = jaddr;
  endtask

  task automatic do_reset(input logic rdy, input logic idr, input int l);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, RV);
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_id_inst", bus.id_inst, 32'd0);
    chk("rst_id_pc", bus.id_pc, 32'd0);
    chk("rst_id_pc4", bus.id_pc4, 32'd0);
    set_redirect(1'b0, 2'b00, 32'd0, 32'd0);
    bus.imem_req_ready = rdy;
    bus.id_ready       = idr;
    lat                = l;
    step(2);
    acc_log.delete();
    dlv_log.delete();
    reset = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int dm, am;
    set_redirect(1'b0, 2'b00, 32'd0, 32'd0);
    bus.imem_req_ready = 1'b0;
    bus.id_ready       = 1'b0;

    // 1: streaming, one instruction per cycle from RESET_VECTOR
    do_reset(1'b1, 1'b1, 1);
    step(12);
    chk("t1_pc0", q_at(dlv_log, 0), 32'h0);
    chk("t1_pc1", q_at(dlv_log, 1), 32'h4);
    chk("t1_pc2", q_at(dlv_log, 2), 32'h8);
    chk("t1_pc3", q_at(dlv_log, 3), 32'hC);
    chk("t1_count", 32'(dlv_log.size()), 32'd9);

    // 2: ID stalled -> exactly DEPTH requests, then ordered drain
    do_reset(1'b1, 1'b0, 1);
    step(10);
    @(negedge clk);
    chk("t2_issued", 32'(acc_log.size()), 32'd4);
    chk("t2_req_valid_low", 32'(bus.imem_req_valid), 32'd0);
    chk("t2_id_valid", 32'(bus.id_valid), 32'd1);
    step(1);
    bus.id_ready = 1'b1;
    step(8);
    chk("t2_pc0", q_at(dlv_log, 0), 32'h0);
    chk("t2_pc3", q_at(dlv_log, 3), 32'hC);
    chk("t2_pc4", q_at(dlv_log, 4), 32'h10);

    // 3: jal with two requests in flight -> both dropped
    do_reset(1'b1, 1'b1, 4);
    for (int i = 0; i < 20 && acc_log.size() < 2; i++) step(1);
    chk("t3_in_flight", 32'(acc_log.size()), 32'd2);
    set_redirect(1'b0, 2'b01, 32'd0, 32'h100);
    step(1);
    set_redirect(1'b0, 2'b00, 32'd0, 32'd0);
    step(16);
    chk("t3_first", q_at(dlv_log, 0), 32'h100);
    chk("t3_second", q_at(dlv_log, 1), 32'h104);

    // 4: jalr wins over a simultaneous branch
    do_reset(1'b1, 1'b1, 1);
    step(6);
    set_redirect(1'b1, 2'b10, 32'h40, 32'h80);
    am = acc_log.size();
    dm = dlv_log.size();
    step(1);
    set_redirect(1'b0, 2'b00, 32'd0, 32'd0);
    step(8);
    chk("t4_fetch", q_at(acc_log, am), 32'h80);
    chk("t4_deliver", q_at(dlv_log, dm), 32'h80);
    chk("t4_deliver_next", q_at(dlv_log, dm + 1), 32'h84);

    // 5: memory back-pressure holds the address; misaligned jump target is aligned
    do_reset(1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      @(negedge clk);
      chk("t5_hold_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("t5_hold_addr", bus.imem_req_addr, RV);
    end
    step(1);
    set_redirect(1'b0, 2'b01, 32'd0, 32'h203);
    step(1);
    set_redirect(1'b0, 2'b00, 32'd0, 32'd0);
    bus.imem_req_ready = 1'b1;
    step(6);
    chk("t5_fetch", q_at(acc_log, 0), 32'h200);
    chk("t5_deliver", q_at(dlv_log, 0), 32'h200);

    // 7: PC wraps past the top of the address space
    do_reset(1'b1, 1'b1, 1);
    step(3);
    set_redirect(1'b0, 2'b01, 32'd0, 32'hFFFF_FFF8);
    dm = dlv_log.size();
    step(1);
    set_redirect(1'b0, 2'b00, 32'd0, 32'd0);
    step(10);
    chk("t7_wrap0", q_at(dlv_log, dm), 32'hFFFF_FFF8);
    chk("t7_wrap1", q_at(dlv_log, dm + 1), 32'hFFFF_FFFC);
    chk("t7_wrap2", q_at(dlv_log, dm + 2), 32'h0);
    chk("t7_wrap3", q_at(dlv_log, dm + 3), 32'h4);

    // 6: asynchronous reset mid-burst, then restart from RESET_VECTOR
    step(4);
    @(negedge clk);
    chk("t6_busy", 32'(bus.id_valid), 32'd1);
    do_reset(1'b1, 1'b1, 1);
    step(6);
    chk("t6_restart", q_at(acc_log, 0), RV);
    chk("t6_restart_deliver", q_at(dlv_log, 0), RV);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
